mainfsm_ctrl: RTL and testbench

//  Main control FSM for the multicycle ARMv4 core. It sequences every instruction through

---
 rtl/mainfsm_ctrl_if.sv | 27 ++
 rtl/mainfsm_ctrl.sv | 114 +++++++++++
 tb/tb_mainfsm_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mainfsm_ctrl_if.sv
// mainfsm_ctrl_if: control bus between the main FSM (master) and the multicycle datapath (slave)
// Ports: Op, Funct, mem_ready from datapath; IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
//        ALUOp, NextPC, RegW, MemW, Branch, illegal to datapath / condition logic
interface mainfsm_ctrl_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       illegal;
    modport master (
        input  Op, Funct, mem_ready,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, illegal
    );
    modport slave (
        output Op, Funct, mem_ready,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, illegal
    );
endinterface

// File: rtl/mainfsm_ctrl.sv
// mainfsm_ctrl: main control FSM of the multicycle ARMv4 core with retired-instruction counter
// Ports: clk, reset_n (sync, active-low), bus (mainfsm_ctrl_if.master), state (debug),
//        instr_count (saturating completed-instruction count)
// Option: define MAINFSM_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE until mem_ready
module mainfsm_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    mainfsm_ctrl_if.master   bus,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] UNKNOWN  = 4'd10;
    logic [3:0] state_nx;
    logic       done;
    logic       mem_ok;
`ifdef MAINFSM_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    // mem_ready is read but has no effect without wait states
    assign mem_ok = bus.mem_ready | 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (!reset_n) state <= FETCH;
        else state <= state_nx;
    end
    // done marks the edge on which an instruction retires
    always_comb begin
        state_nx = FETCH;
        done = 1'b0;
        case (state)
            FETCH:    state_nx = mem_ok ? DECODE : FETCH;
            DECODE:   state_nx = bus.Op == 2'b01 ? MEMADR :
                                 bus.Op == 2'b10 ? BRANCH :
                                 bus.Op == 2'b11 ? UNKNOWN :
                                 bus.Funct[5] ? EXECUTEI : EXECUTER;
            MEMADR:   state_nx = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_nx = mem_ok ? MEMWB : MEMREAD;
            MEMWRITE: begin
                state_nx = mem_ok ? FETCH : MEMWRITE;
                done = mem_ok;
            end
            EXECUTER, EXECUTEI: state_nx = ALUWB;
            MEMWB, ALUWB, BRANCH: done = 1'b1;
            default: state_nx = FETCH;
        endcase
    end
    // enables are gated by reset_n so nothing writes while reset is held
    always_comb begin
        bus.IRWrite = 1'b0;
        bus.AdrSrc = 1'b0;
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.ALUOp = 1'b0;
        bus.NextPC = 1'b0;
        bus.RegW = 1'b0;
        bus.MemW = 1'b0;
        bus.Branch = 1'b0;
        bus.illegal = 1'b0;
        case (state)
            FETCH: begin
                bus.IRWrite = reset_n & mem_ok;
                bus.NextPC = reset_n & mem_ok;
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR:   bus.ALUSrcB = 2'b01;
            MEMREAD:  bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegW = reset_n;
            end
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                bus.MemW = reset_n;
            end
            EXECUTER: bus.ALUOp = 1'b1;
            EXECUTEI: begin
                bus.ALUSrcB = 2'b01;
                bus.ALUOp = 1'b1;
            end
            ALUWB:    bus.RegW = reset_n;
            BRANCH: begin
                bus.ALUSrcB = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.Branch = reset_n;
            end
            UNKNOWN:  bus.illegal = reset_n;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) instr_count <= '0;
        else if (done && !(&instr_count)) instr_count <= instr_count + 1'b1;
    end
endmodule

// File: tb/tb_mainfsm_ctrl.sv
// tb_mainfsm_ctrl: scoreboard bench for mainfsm_ctrl using directed instruction sequences
module tb_mainfsm_ctrl;
    localparam int CNT_W = 3;
    typedef struct packed {
        logic [3:0]       s;
        logic [12:0]      o;
        logic [CNT_W-1:0] c;
    } exp_t;
    logic clk;
    logic reset_n;
    logic [3:0] state;
    logic [CNT_W-1:0] instr_count;
    exp_t sb[$];
    exp_t e;
    logic [12:0] act;
    int n_chk = 0;
    int n_fail = 0;
    mainfsm_ctrl_if bus ();
    mainfsm_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.master),
        .state(state),
        .instr_count(instr_count)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch,illegal}
    function automatic logic [12:0] exp_out(input logic [3:0] s);
        logic [12:0] v;
        case (s)
            4'd0:    v = 13'b1_0_1_10_10_0_1_0_0_0_0;
            4'd1:    v = 13'b0_0_1_10_10_0_0_0_0_0_0;
            4'd2:    v = 13'b0_0_0_01_00_0_0_0_0_0_0;
            4'd3:    v = 13'b0_1_0_00_00_0_0_0_0_0_0;
            4'd4:    v = 13'b0_0_0_00_01_0_0_1_0_0_0;
            4'd5:    v = 13'b0_1_0_00_00_0_0_0_1_0_0;
            4'd6:    v = 13'b0_0_0_00_00_1_0_0_0_0_0;
            4'd7:    v = 13'b0_0_0_01_00_1_0_0_0_0_0;
            4'd8:    v = 13'b0_0_0_00_00_0_0_1_0_0_0;
            4'd9:    v = 13'b0_0_0_01_10_0_0_0_0_1_0;
            4'd10:   v = 13'b0_0_0_00_00_0_0_0_0_0_1;
            default: v = 13'b0;
        endcase
        if (!reset_n) v = v & 13'b0_1_1_11_11_1_0_0_0_0_0;
`ifdef MAINFSM_MEM_WAIT_EN
        if (!bus.mem_ready) v = v & 13'b0_1_1_11_11_1_0_1_1_1_1;
`endif
        return v;
    endfunction
    task automatic cycle(input logic [3:0] s, input logic [CNT_W-1:0] c);
        sb.push_back({s, exp_out(s), c});
        @(posedge clk);
        #1;
    endtask
    task automatic instr(input logic [1:0] op, input logic [5:0] f, input logic [19:0] seq,
                         input int n, input logic [CNT_W-1:0] c);
        bus.Op = op;
        bus.Funct = f;
        for (int i = 0; i < n; i++) cycle(seq[19-4*i -: 4], c);
    endtask
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp,
                   bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.illegal};
            n_chk += 3;
            if (state !== e.s) begin
                n_fail++;
                $display("FAIL state: got %0d expected %0d at %0t", state, e.s, $time);
            end
            if (act !== e.o) begin
                n_fail++;
                $display("FAIL outputs: got %b expected %b (state %0d) at %0t", act, e.o, e.s, $time);
            end
            if (instr_count !== e.c) begin
                n_fail++;
                $display("FAIL instr_count: got %0d expected %0d at %0t", instr_count, e.c, $time);
            end
        end
    end
    initial begin
        reset_n = 1'b0;
        bus.Op = 2'b00;
        bus.Funct = 6'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle(4'd0, 0);
        cycle(4'd0, 0);
        reset_n = 1'b1;
        instr(2'b00, 6'b001000, 20'h01680, 4, 0);
        instr(2'b01, 6'b011001, 20'h01234, 5, 1);
        instr(2'b01, 6'b011000, 20'h01250, 4, 2);
        instr(2'b10, 6'b000000, 20'h01900, 3, 3);
        instr(2'b11, 6'b000000, 20'h01A00, 3, 4);
`ifndef MAINFSM_MEM_WAIT_EN
        bus.mem_ready = 1'b0;
`endif
        instr(2'b00, 6'b101000, 20'h01780, 4, 4);
        bus.mem_ready = 1'b1;
        instr(2'b01, 6'b011001, 20'h01230, 3, 5);
        reset_n = 1'b0;
        cycle(4'd3, 5);
        cycle(4'd0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) instr(2'b10, 6'b000000, 20'h01900, 3, CNT_W'(i));
`ifdef MAINFSM_MEM_WAIT_EN
        bus.Op = 2'b01;
        bus.Funct = 6'b011000;
        bus.mem_ready = 1'b0;
        cycle(4'd0, 7);
        cycle(4'd0, 7);
        cycle(4'd0, 7);
        bus.mem_ready = 1'b1;
        cycle(4'd0, 7);
        cycle(4'd1, 7);
        cycle(4'd2, 7);
        bus.mem_ready = 1'b0;
        cycle(4'd5, 7);
        cycle(4'd5, 7);
        bus.mem_ready = 1'b1;
        cycle(4'd5, 7);
`endif
        cycle(4'd0, 7);
        repeat (2) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
